// File: rtl/sum_pkg.sv
// Shared definitions for the sum_pipe adder pipeline: operation modes and
// the legal parameter ranges.
package sum_pkg;

  typedef enum logic [1:0] {
    WRAP = 2'd0,
    SAT  = 2'd1,
    ACC  = 2'd2
  } mode_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 4;

endpackage

// File: rtl/sum_stage.sv
// One valid/ready register slice carrying a result word and its overflow flag.
// The slice loads whenever it is empty or its consumer is taking the current beat.
module sum_stage
  import sum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_ovf,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_c,
  output logic             out_ovf,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    valid_d = valid_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    if (!valid_q || out_ready) begin
      valid_d = in_valid;
      // Payload only moves with a real beat so a stalled output never changes.
      if (in_valid) begin
        c_d   = in_c;
        ovf_d = in_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_c     = c_q;
  assign out_ovf   = ovf_q;

endmodule

// File: rtl/sum_pipe.sv
// Wrapping / saturating / accumulating adder whose result is computed on input
// accept and then carried through DEPTH valid/ready register slices.
module sum_pipe
  import sum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] c,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [DEPTH:0]   stage_valid;
  logic [DEPTH:0]   stage_ovf;
  logic [WIDTH-1:0] stage_c [DEPTH+1];
  logic [DEPTH:0]   down_ready;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH+1:0] base_ext;
  logic [WIDTH+1:0] sum_ext;
  logic [WIDTH-1:0] res_c;
  logic             res_ovf;
  logic             accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    base_ext = '0;
    // A clear arriving with an ACC beat means that beat starts from zero.
    if (mode == ACC && !clr) begin
      base_ext = {2'b00, acc_q};
    end
    sum_ext = base_ext + {2'b00, a} + {2'b00, b};
    res_c   = sum_ext[WIDTH-1:0];
    res_ovf = sum_ext[WIDTH];
    case (mode)
      SAT: begin
        if (sum_ext[WIDTH]) begin
          res_c = '1;
        end
      end
      ACC:     res_ovf = |sum_ext[WIDTH+1:WIDTH];
      default: ;
    endcase

    acc_d = acc_q;
    if (accept && mode == ACC) begin
      acc_d = res_c;
    end else if (clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Ready of slice i is derived from the registered valids downstream of it,
  // which keeps the ready chain free of loops through the slice instances.
  always_comb begin
    down_ready        = '0;
    down_ready[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      down_ready[i] = !stage_valid[i+1] || down_ready[i+1];
    end
  end

  assign stage_valid[0] = in_valid;
  assign stage_c[0]     = res_c;
  assign stage_ovf[0]   = res_ovf;
  assign in_ready       = down_ready[0] && aresetn;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      sum_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (clk),
        .aresetn  (aresetn),
        .in_valid (stage_valid[gi]),
        .in_c     (stage_c[gi]),
        .in_ovf   (stage_ovf[gi]),
        .out_valid(stage_valid[gi+1]),
        .out_c    (stage_c[gi+1]),
        .out_ovf  (stage_ovf[gi+1]),
        .out_ready(down_ready[gi+1])
      );
    end
  endgenerate

  assign out_valid = stage_valid[DEPTH];
  assign c         = stage_c[DEPTH];
  assign ovf       = stage_ovf[DEPTH];

endmodule

// File: tb/tb_sum_pipe.sv
// Directed plus randomized bench for sum_pipe (WIDTH=8, DEPTH=2) against an
// arithmetic reference model with an in-flight queue.
module tb_sum_pipe;
  import sum_pkg::*;

  localparam int W    = 8;
  localparam int D    = 2;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [1:0]   mode;
  logic         clr;
  logic [W-1:0] a, b;
  logic         in_valid, in_ready;
  logic [W-1:0] c;
  logic         ovf, out_valid, out_ready;

  always #5 clk = ~clk;

  sum_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .aresetn(aresetn), .mode(mode), .clr(clr), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .c(c), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [W-1:0] c;
    logic         ovf;
    int           acc_edge;
  } exp_t;

  exp_t         q[$];
  logic [W:0]   got[$];
  int           n_cmp = 0, n_bad = 0, edge_cnt = 0, acc_m = 0, ir_low = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_c = '0;
  logic         prev_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_beat(input int m, input int aa, input int bb, input bit cl,
                                   output logic [W-1:0] rc, output logic rovf);
    int s;
    if (m == 1) begin
      s = aa + bb;
      rovf = (s > MAXV);
      rc = rovf ? W'(MAXV) : W'(s);
    end else if (m == 2) begin
      s = (cl ? 0 : acc_m) + aa + bb;
      rc = W'(s % (MAXV + 1));
      rovf = (s > MAXV);
      acc_m = int'(rc);
    end else begin
      s = aa + bb;
      rc = W'(s % (MAXV + 1));
      rovf = (s > MAXV);
    end
  endfunction

  task automatic step(input logic rst_n_i, input logic v, input logic [1:0] m,
                      input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic cl, input logic ordy, output bit took);
    logic         exp_ir, exp_ov, rovf;
    logic [W-1:0] rc;
    exp_t         e;
    @(negedge clk);
    aresetn = rst_n_i; in_valid = v; mode = m; a = aa; b = bb; clr = cl; out_ready = ordy;
    #4;
    exp_ir = rst_n_i && (q.size() < D || ordy);
    exp_ov = (q.size() > 0) && (edge_cnt - q[0].acc_edge >= D - 1);
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, exp_ov);
    if (!in_ready) ir_low++;
    if (exp_ov) begin
      check("c", c, q[0].c);
      check("ovf", ovf, q[0].ovf);
    end
    if (prev_stall) begin
      check("stall_c", c, prev_c);
      check("stall_ovf", ovf, prev_ovf);
    end
    prev_stall = rst_n_i && exp_ov && !ordy;
    prev_c = c;
    prev_ovf = ovf;
    took = v && exp_ir;
    if (!rst_n_i) begin
      q.delete();
      acc_m = 0;
    end else begin
      if (exp_ov && ordy) begin
        got.push_back({ovf, c});
        void'(q.pop_front());
      end
      if (took) begin
        ref_beat(int'(m), int'(aa), int'(bb), cl, rc, rovf);
        e.c = rc; e.ovf = rovf; e.acc_edge = edge_cnt + 1;
        q.push_back(e);
      end
      if (cl && !(took && m == 2'd2)) acc_m = 0;
    end
    @(posedge clk);
    edge_cnt++;
    $display("t=%0t v=%0b m=%0d a=%0d b=%0d clr=%0b ordy=%0b | in_ready=%0b out_valid=%0b c=%0d ovf=%0b",
             $time, v, m, aa, bb, cl, ordy, in_ready, out_valid, c, ovf);
  endtask

  initial begin
    int unsigned  seed;
    bit           tk;
    int           k;
    logic [1:0]   rm;
    logic [W-1:0] ra, rb;
    seed = 32'd20240611;
    void'($urandom(seed));
    $display("random seed (process state) = %0d", seed);

    aresetn = 1'b0; in_valid = 1'b0; mode = 2'd0; clr = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    step(0, 0, WRAP, 0, 0, 0, 1, tk);
    #1;
    check("rst_c", c, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);

    // WRAP directed
    got.delete();
    step(1, 1, WRAP, 200, 100, 0, 1, tk);
    repeat (2) step(1, 0, WRAP, 0, 0, 0, 1, tk);
    check("wrap_n", got.size(), 1);
    check("wrap_c", got[0][W-1:0], 44);
    check("wrap_ovf", got[0][W], 1);

    // SAT directed
    got.delete();
    step(1, 1, SAT, 200, 100, 0, 1, tk);
    step(1, 1, SAT, 10, 20, 0, 1, tk);
    repeat (2) step(1, 0, WRAP, 0, 0, 0, 1, tk);
    check("sat_n", got.size(), 2);
    check("sat_c0", got[0], {1'b1, 8'd255});
    check("sat_c1", got[1], {1'b0, 8'd30});

    // ACC directed, then clear alongside an ACC beat
    got.delete();
    step(1, 1, ACC, 10, 5, 0, 1, tk);
    step(1, 1, ACC, 20, 0, 0, 1, tk);
    step(1, 1, ACC, 250, 0, 0, 1, tk);
    repeat (2) step(1, 0, WRAP, 0, 0, 0, 1, tk);
    step(1, 1, ACC, 1, 1, 1, 1, tk);
    repeat (2) step(1, 0, WRAP, 0, 0, 0, 1, tk);
    check("acc_n", got.size(), 4);
    check("acc_0", got[0], {1'b0, 8'd15});
    check("acc_1", got[1], {1'b0, 8'd35});
    check("acc_2", got[2], {1'b1, 8'd29});
    check("acc_clr", got[3], {1'b0, 8'd2});

    // Six random beats with a 4-cycle output stall mid-stream
    got.delete();
    ir_low = 0;
    k = 0;
    rm = 2'($urandom_range(0, 3)); ra = W'($urandom); rb = W'($urandom);
    for (int cyc = 0; cyc < 30; cyc++) begin
      step(1, k < 6, rm, ra, rb, 0, !(cyc >= 2 && cyc < 6), tk);
      if (tk) begin
        k++;
        rm = 2'($urandom_range(0, 3)); ra = W'($urandom); rb = W'($urandom);
      end
    end
    check("bp_accepted", k, 6);
    check("bp_out_n", got.size(), 6);
    check("bp_in_ready_low", ir_low, 4);

    // Random soak with random backpressure and clears
    for (int i = 0; i < 80; i++) begin
      step(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, tk);
    end
    repeat (4) step(1, 0, WRAP, 0, 0, 0, 1, tk);

    // Reset with two beats in flight and a non-zero accumulator
    step(1, 1, ACC, 7, 0, 0, 1, tk);
    repeat (2) step(1, 0, WRAP, 0, 0, 0, 1, tk);
    got.delete();
    step(1, 1, WRAP, 1, 2, 0, 0, tk);
    step(1, 1, WRAP, 3, 4, 0, 0, tk);
    step(0, 0, WRAP, 0, 0, 0, 0, tk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    step(1, 1, ACC, 1, 2, 0, 1, tk);
    repeat (3) step(1, 0, WRAP, 0, 0, 0, 1, tk);
    check("midrst_n", got.size(), 1);
    check("midrst_acc", got[0], {1'b0, 8'd3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
